// File: rtl/tracker_sequencer.sv
// Pattern sequencer for the tracker synth core: plays rows of note words from a
// local pattern RAM at a programmable tempo, applying fade effects per tick.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | stopped; waiting for start, pattern length/tempo latched here
// S_RD    | pattern RAM address presented, read data registered
// S_LD    | row data loaded into note_out/speed_out, row_strobe pulsed
// S_PLAY  | row sounding; tick down-counters run, fade effects applied
module tracker_sequencer #(
   parameter int ROWS     = 64,
   parameter int ROWLEN   = $clog2(ROWS),
   parameter int TICK_DIV = 256,
   parameter int MAXSPEED = 16,
   parameter int SPLEN    = $clog2(MAXSPEED)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ROWLEN-1:0] wr_addr,
   input  logic [15:0]       wr_data,
   input  logic [ROWLEN:0]   pattern_len,
   input  logic [7:0]        ticks_per_row,
   input  logic              loop,
   input  logic              start,
   input  logic              stop,
   output logic [15:0]       note_out,
   output logic [SPLEN-1:0]  speed_out,
   output logic [ROWLEN-1:0] row_idx,
   output logic              row_strobe,
   output logic              busy,
   output logic              done
);

   localparam int CYCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CYCW-1:0]  CYC_TC  = CYCW'(TICK_DIV - 1);
   localparam logic [SPLEN-1:0] SPD_MAX = '1;
   localparam logic [2:0] FX_FADE_IN  = 3'd4;
   localparam logic [2:0] FX_FADE_OUT = 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_RD, S_LD, S_PLAY} state_t;

   state_t            state, state_nx;
   logic [ROWLEN-1:0] row, row_nx;
   logic [ROWLEN-1:0] last_row;
   logic [7:0]        tpr_m1;
   logic [CYCW-1:0]   cyc_cnt;
   logic [7:0]        tick_cnt;
   logic [4:0]        vol_tgt;
   logic [15:0]       ram [ROWS];
   logic [15:0]       ram_q;

   logic              tick, row_end, do_done, do_kill, go;
   logic [ROWLEN:0]   len_c;
   logic [10:0]       spd_wide;
   logic [SPLEN-1:0]  spd_sat;
   logic [4:0]        vol_ld;

   assign busy    = (state != S_IDLE);
   assign go      = (state == S_IDLE) && start && !stop;
   assign tick    = (state == S_PLAY) && (cyc_cnt == '0);
   assign row_end = tick && (tick_cnt == 8'd0);

   always_comb begin
      if (pattern_len == '0)
         len_c = (ROWLEN+1)'(1);
      else if (pattern_len > (ROWLEN+1)'(ROWS))
         len_c = (ROWLEN+1)'(ROWS);
      else
         len_c = pattern_len;
   end

   // Widest case is 8 << 7, so 11 bits hold the unsaturated step.
   always_comb begin
      spd_wide = {7'd0, ({1'b0, ram_q[15:13]} + 4'd1)} << ram_q[12:10];
      if (spd_wide > {{(11-SPLEN){1'b0}}, SPD_MAX})
         spd_sat = SPD_MAX;
      else
         spd_sat = spd_wide[SPLEN-1:0];
      vol_ld = (ram_q[2:0] == FX_FADE_IN) ? 5'd0 : ram_q[7:3];
   end

   always_comb begin
      state_nx = state;
      row_nx   = row;
      do_done  = 1'b0;
      do_kill  = 1'b0;
      case (state)
         S_IDLE: begin
            if (go) begin
               state_nx = S_RD;
               row_nx   = '0;
            end
         end
         S_RD:   state_nx = S_LD;
         S_LD:   state_nx = S_PLAY;
         S_PLAY: begin
            if (row_end) begin
               if (row != last_row) begin
                  row_nx   = row + ROWLEN'(1);
                  state_nx = S_RD;
               end else if (loop) begin
                  row_nx   = '0;
                  state_nx = S_RD;
               end else begin
                  state_nx = S_IDLE;
                  do_done  = 1'b1;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
      // stop overrides everything, including a row end on the same edge
      if (stop && (state != S_IDLE)) begin
         state_nx = S_IDLE;
         do_kill  = 1'b1;
         do_done  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         row   <= '0;
      end else begin
         state <= state_nx;
         row   <= row_nx;
      end
   end

   // Pattern RAM is deliberately not reset; read-before-write on collision.
   always_ff @(posedge clk) begin
      if (wr_en)
         ram[wr_addr] <= wr_data;
      if (state == S_RD)
         ram_q <= ram[row];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         note_out   <= '0;
         speed_out  <= '0;
         row_idx    <= '0;
         row_strobe <= 1'b0;
         done       <= 1'b0;
         last_row   <= '0;
         tpr_m1     <= '0;
         cyc_cnt    <= '0;
         tick_cnt   <= '0;
         vol_tgt    <= '0;
      end else begin
         row_strobe <= 1'b0;
         done       <= do_done;
         if (go) begin
            last_row <= ROWLEN'(len_c - (ROWLEN+1)'(1));
            tpr_m1   <= (ticks_per_row == 8'd0) ? 8'd0 : ticks_per_row - 8'd1;
         end
         if (state == S_LD) begin
            note_out   <= {ram_q[15:8], vol_ld, ram_q[2:0]};
            vol_tgt    <= ram_q[7:3];
            speed_out  <= spd_sat;
            row_idx    <= row;
            row_strobe <= 1'b1;
            cyc_cnt    <= CYC_TC;
            tick_cnt   <= tpr_m1;
         end else if (state == S_PLAY) begin
            if (tick) begin
               cyc_cnt <= CYC_TC;
               if (tick_cnt != 8'd0)
                  tick_cnt <= tick_cnt - 8'd1;
               if ((note_out[2:0] == FX_FADE_IN) && (note_out[7:3] < vol_tgt))
                  note_out[7:3] <= note_out[7:3] + 5'd1;
               else if ((note_out[2:0] == FX_FADE_OUT) && (note_out[7:3] != 5'd0))
                  note_out[7:3] <= note_out[7:3] - 5'd1;
            end else begin
               cyc_cnt <= cyc_cnt - CYCW'(1);
            end
         end
         // silence the tracker whenever playback ends, but keep pitch fields
         if (do_kill || do_done)
            note_out[7:3] <= 5'd0;
      end
   end

endmodule

// File: tb/tb_tracker_sequencer.sv
// Directed bench for tracker_sequencer with a short tick (TICK_DIV=4); each task
// drives one scenario and checks against hand-computed cycle positions.
module tb_tracker_sequencer;

   localparam int ROWS = 64;
   localparam int ROWLEN = 6;
   localparam int TD = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              wr_en;
   logic [ROWLEN-1:0] wr_addr;
   logic [15:0]       wr_data;
   logic [ROWLEN:0]   pattern_len;
   logic [7:0]        ticks_per_row;
   logic              loop;
   logic              start;
   logic              stop;
   logic [15:0]       note_out;
   logic [3:0]        speed_out;
   logic [ROWLEN-1:0] row_idx;
   logic              row_strobe;
   logic              busy;
   logic              done;

   int n_pass = 0;
   int n_total = 0;

   tracker_sequencer #(.ROWS(ROWS), .TICK_DIV(TD), .MAXSPEED(16)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .pattern_len(pattern_len), .ticks_per_row(ticks_per_row), .loop(loop),
      .start(start), .stop(stop), .note_out(note_out), .speed_out(speed_out),
      .row_idx(row_idx), .row_strobe(row_strobe), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] nw(input int tone, input int oct, input int inst,
                                      input int vol, input int fx);
      nw = {3'(tone), 3'(oct), 2'(inst), 5'(vol), 3'(fx)};
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr_row(input int addr, input logic [15:0] data);
      wr_en = 1'b1; wr_addr = ROWLEN'(addr); wr_data = data;
      cyc(1);
      wr_en = 1'b0;
   endtask

   // start is sampled on the next edge (E0); returns 1 time unit after E0
   task automatic pulse_start;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic load_basic;
      wr_row(0, nw(0, 0, 0, 31, 0));
      wr_row(1, nw(3, 1, 0, 31, 0));
      wr_row(2, nw(7, 1, 0, 31, 0));
   endtask

   task automatic test_reset;
      cyc(2);
      n_total++;
      if ({note_out, speed_out, row_idx, row_strobe, busy, done} !== '0) $display("FAIL reset_hold outputs=%h expected 0", {note_out, speed_out, row_idx, row_strobe, busy, done}); else n_pass++;
      #2 rst_n = 1'b1;
      cyc(4);
      n_total++;
      if (busy !== 1'b0) $display("FAIL reset_idle busy=%b expected 0", busy); else n_pass++;
      load_basic();
      pattern_len = 3; ticks_per_row = 2; loop = 1'b0;
      pulse_start();
      cyc(14);
      n_total++;
      if (busy !== 1'b1 || row_idx !== 6'd1) $display("FAIL reset_pre busy=%b row_idx=%0d expected 1/1", busy, row_idx); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if ({note_out, speed_out, row_idx, row_strobe, busy, done} !== '0) $display("FAIL reset_async outputs=%h expected 0", {note_out, speed_out, row_idx, row_strobe, busy, done}); else n_pass++;
      #1 rst_n = 1'b1;
      cyc(12);
      n_total++;
      if (busy !== 1'b0 || row_strobe !== 1'b0) $display("FAIL reset_after busy=%b strobe=%b expected 0/0", busy, row_strobe); else n_pass++;
   endtask

   task automatic test_basic;
      logic [15:0] r2;
      logic        exp_s;
      r2 = nw(7, 1, 0, 31, 0);
      load_basic();
      pattern_len = 3; ticks_per_row = 2; loop = 1'b0;
      pulse_start();
      for (int k = 1; k <= 32; k++) begin
         cyc(1);
         exp_s = (k == 2 || k == 12 || k == 22);
         n_total++;
         if (row_strobe !== exp_s) $display("FAIL basic_strobe k=%0d got=%b expected=%b", k, row_strobe, exp_s); else n_pass++;
         n_total++;
         if (done !== (k == 30)) $display("FAIL basic_done k=%0d got=%b expected=%b", k, done, (k == 30)); else n_pass++;
         if (k == 1) begin
            n_total++;
            if (busy !== 1'b1) $display("FAIL basic_busy got=%b expected 1", busy); else n_pass++;
         end
         if (k == 2) begin
            n_total++;
            if (speed_out !== 4'd1 || row_idx !== 6'd0 || note_out !== nw(0, 0, 0, 31, 0)) $display("FAIL basic_row0 speed=%0d idx=%0d note=%h expected 1/0/%h", speed_out, row_idx, note_out, nw(0, 0, 0, 31, 0)); else n_pass++;
         end
         if (k == 12) begin
            n_total++;
            if (speed_out !== 4'd8 || row_idx !== 6'd1) $display("FAIL basic_row1 speed=%0d idx=%0d expected 8/1", speed_out, row_idx); else n_pass++;
         end
         if (k == 22) begin
            n_total++;
            if (speed_out !== 4'd15 || row_idx !== 6'd2) $display("FAIL basic_row2 speed=%0d idx=%0d expected 15/2", speed_out, row_idx); else n_pass++;
         end
         if (k == 30) begin
            n_total++;
            if (busy !== 1'b0 || note_out !== {r2[15:8], 5'd0, r2[2:0]}) $display("FAIL basic_end busy=%b note=%h expected 0/%h", busy, note_out, {r2[15:8], 5'd0, r2[2:0]}); else n_pass++;
         end
      end
   endtask

   task automatic test_loop_stop;
      logic exp_s;
      load_basic();
      pattern_len = 3; ticks_per_row = 2; loop = 1'b1;
      pulse_start();
      for (int k = 1; k <= 45; k++) begin
         cyc(1);
         exp_s = (k >= 2) && ((k - 2) % 10 == 0);
         n_total++;
         if (row_strobe !== exp_s || done !== 1'b0) $display("FAIL loop_strobe k=%0d strobe=%b done=%b expected %b/0", k, row_strobe, done, exp_s); else n_pass++;
         if (k == 32 || k == 42) begin
            n_total++;
            if (row_idx !== ((k == 32) ? 6'd0 : 6'd1)) $display("FAIL loop_idx k=%0d got=%0d expected=%0d", k, row_idx, (k == 32) ? 0 : 1); else n_pass++;
         end
      end
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      n_total++;
      if (busy !== 1'b0 || note_out[7:3] !== 5'd0 || done !== 1'b0) $display("FAIL stop_now busy=%b vol=%0d done=%b expected 0/0/0", busy, note_out[7:3], done); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         cyc(1);
         n_total++;
         if (done !== 1'b0 || busy !== 1'b0) $display("FAIL stop_after k=%0d done=%b busy=%b expected 0/0", k, done, busy); else n_pass++;
      end
      loop = 1'b0;
   endtask

   task automatic test_fade(input int fx, input int vol);
      int exp_v;
      wr_row(0, nw(2, 0, 1, vol, fx));
      pattern_len = 1; ticks_per_row = 8; loop = 1'b0;
      pulse_start();
      for (int k = 1; k <= 34; k++) begin
         cyc(1);
         if (k >= 2) begin
            if (k == 34) exp_v = 0;
            else if (fx == 4) exp_v = ((k - 2) / TD > vol) ? vol : (k - 2) / TD;
            else exp_v = (vol - (k - 2) / TD < 0) ? 0 : vol - (k - 2) / TD;
            n_total++;
            if (note_out[7:3] !== 5'(exp_v)) $display("FAIL fade_vol fx=%0d k=%0d got=%0d expected=%0d", fx, k, note_out[7:3], exp_v); else n_pass++;
         end
      end
      n_total++;
      if (done !== 1'b1) $display("FAIL fade_done fx=%0d got=%b expected 1", fx, done); else n_pass++;
   endtask

   task automatic test_start_stop_same;
      start = 1'b1; stop = 1'b1;
      cyc(1);
      start = 1'b0; stop = 1'b0;
      n_total++;
      if (busy !== 1'b0) $display("FAIL startstop_busy got=%b expected 0", busy); else n_pass++;
      cyc(2);
      n_total++;
      if (row_strobe !== 1'b0 || busy !== 1'b0) $display("FAIL startstop_strobe strobe=%b busy=%b expected 0/0", row_strobe, busy); else n_pass++;
   endtask

   task automatic test_start_busy;
      load_basic();
      pattern_len = 3; ticks_per_row = 2; loop = 1'b0;
      pulse_start();
      cyc(5);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(6);
      n_total++;
      if (row_strobe !== 1'b1 || row_idx !== 6'd1) $display("FAIL busy_start strobe=%b idx=%0d expected 1/1", row_strobe, row_idx); else n_pass++;
      cyc(18);
      n_total++;
      if (done !== 1'b1) $display("FAIL busy_start_done got=%b expected 1", done); else n_pass++;
   endtask

   task automatic test_tpr_zero;
      load_basic();
      pattern_len = 2; ticks_per_row = 0; loop = 1'b0;
      pulse_start();
      cyc(7);
      n_total++;
      if (row_strobe !== 1'b0) $display("FAIL tpr0_early got=%b expected 0", row_strobe); else n_pass++;
      cyc(1);
      n_total++;
      if (row_strobe !== 1'b1 || row_idx !== 6'd1) $display("FAIL tpr0_row1 strobe=%b idx=%0d expected 1/1", row_strobe, row_idx); else n_pass++;
      cyc(4);
      n_total++;
      if (done !== 1'b1 || busy !== 1'b0) $display("FAIL tpr0_done done=%b busy=%b expected 1/0", done, busy); else n_pass++;
   endtask

   task automatic test_len_zero;
      load_basic();
      pattern_len = 0; ticks_per_row = 1; loop = 1'b0;
      pulse_start();
      cyc(2);
      n_total++;
      if (row_strobe !== 1'b1 || row_idx !== 6'd0) $display("FAIL len0_row0 strobe=%b idx=%0d expected 1/0", row_strobe, row_idx); else n_pass++;
      cyc(4);
      n_total++;
      if (done !== 1'b1 || busy !== 1'b0) $display("FAIL len0_done done=%b busy=%b expected 1/0", done, busy); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         cyc(1);
         n_total++;
         if (row_strobe !== 1'b0) $display("FAIL len0_extra k=%0d strobe=%b expected 0", k, row_strobe); else n_pass++;
      end
   endtask

   task automatic test_ram_collision;
      logic [15:0] new_w;
      new_w = nw(5, 0, 1, 20, 0);
      load_basic();
      pattern_len = 3; ticks_per_row = 2; loop = 1'b1;
      pulse_start();
      cyc(10);
      wr_en = 1'b1; wr_addr = 6'd1; wr_data = new_w;
      cyc(1);
      wr_en = 1'b0;
      cyc(1);
      n_total++;
      if (row_strobe !== 1'b1 || note_out !== nw(3, 1, 0, 31, 0)) $display("FAIL coll_old strobe=%b note=%h expected 1/%h", row_strobe, note_out, nw(3, 1, 0, 31, 0)); else n_pass++;
      cyc(30);
      n_total++;
      if (row_strobe !== 1'b1 || note_out !== new_w || speed_out !== 4'd6) $display("FAIL coll_new strobe=%b note=%h speed=%0d expected 1/%h/6", row_strobe, note_out, speed_out, new_w); else n_pass++;
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      loop = 1'b0;
      n_total++;
      if (busy !== 1'b0) $display("FAIL coll_stop busy=%b expected 0", busy); else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      pattern_len = '0; ticks_per_row = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
      test_reset();
      test_basic();
      test_loop_stop();
      test_fade(4, 5);
      test_fade(5, 3);
      test_start_stop_same();
      test_start_busy();
      test_tpr_zero();
      test_len_zero();
      test_ram_collision();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
